// File: rtl/phased_cache_pkg.sv
// Shared types and address-field constants for the phased cache controller.
package phased_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DATA,
        ST_MEM_REQ,
        ST_REFILL
    } state_t;

    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 2;
    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 2;

    // Byte-address field positions: {tag, index, offset}
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    // One-hot set select for the tag/data arrays
    function automatic logic [NUM_SETS-1:0] decode_index(input logic [INDEX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/phased_cache_ctrl_if.sv
// CPU request port of the phased cache controller.
// master = requester (CPU), slave = cache controller.
interface phased_cache_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_busy;
    logic              cpu_done;
    logic              cpu_hit;

    modport master (
        output cpu_req, cpu_rw, cpu_addr,
        input  cpu_busy, cpu_done, cpu_hit
    );

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr,
        output cpu_busy, cpu_done, cpu_hit
    );
endinterface

// File: rtl/lru_bits_2way.sv
// One LRU bit per set for the 2-way cache; the stored bit names the
// least-recently used way, i.e. the replacement victim.
module lru_bits_2way
    import phased_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic               wdata,
    input  logic [INDEX_W-1:0] raddr,
    output logic               rdata
);

    logic [NUM_SETS-1:0] lru;

    // Per-set LRU flops, cleared by async reset, single write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lru <= '0;
        end else if (we) begin
            lru[waddr] <= wdata;
        end
    end

    assign rdata = lru[raddr];

endmodule

// File: rtl/phased_cache_ctrl.sv
// Sequencing FSM for the 2-way, 4-set phased cache.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for cpu_req; latches address and rw on accept
// ST_LOOKUP  | tag arrays read; hit -> DATA, miss -> MEM_REQ
// ST_DATA    | one way's data array enabled; cpu_done pulse; LRU update
// ST_MEM_REQ | line fetch requested, waiting for mem_ack
// ST_REFILL  | victim way loads line and tag; replay via LOOKUP
module phased_cache_ctrl
    import phased_cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
)(
    input  logic                clk,
    input  logic                reset,
    phased_cache_ctrl_if.slave  cpu,
    input  logic                tag_hit0,
    input  logic                tag_hit1,
    input  logic                tag_valid0,
    input  logic                tag_valid1,
    output logic [INDEX_W-1:0]  index,
    output logic [NUM_SETS-1:0] index_dec,
    output logic [OFFSET_W-1:0] offset,
    output logic                cycle_en,
    output logic                rw,
    output logic                hit_way0,
    output logic                hit_way1,
    output logic                load_way0,
    output logic                load_way1,
    output logic                mem_req,
    output logic [ADDR_W-5:0]   mem_addr,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    miss_count
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              sel_q;
    logic              miss_q;
    logic              victim_q;
    logic              lru_victim;
    logic              victim_nxt;

    assign index    = addr_q[INDEX_LSB +: INDEX_W];
    assign offset   = addr_q[OFFSET_LSB +: OFFSET_W];
    assign mem_addr = addr_q[ADDR_W-1:INDEX_LSB];
    assign rw       = rw_q;

    // Invalid ways are filled before any valid way is evicted
    assign victim_nxt = !tag_valid0 ? 1'b0 :
                        !tag_valid1 ? 1'b1 : lru_victim;

    lru_bits_2way u_lru (
        .clk   (clk),
        .reset (reset),
        .we    (state == ST_DATA),
        .waddr (index),
        .wdata (~sel_q),
        .raddr (index),
        .rdata (lru_victim)
    );

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            sel_q        <= 1'b0;
            miss_q       <= 1'b0;
            victim_q     <= 1'b0;
            index_dec    <= '0;
            cpu.cpu_busy <= 1'b0;
            cpu.cpu_done <= 1'b0;
            cpu.cpu_hit  <= 1'b0;
            cycle_en     <= 1'b0;
            hit_way0     <= 1'b0;
            hit_way1     <= 1'b0;
            load_way0    <= 1'b0;
            load_way1    <= 1'b0;
            mem_req      <= 1'b0;
            miss_count   <= '0;
        end else begin
            cpu.cpu_done <= 1'b0;
            cpu.cpu_hit  <= 1'b0;
            cycle_en     <= 1'b0;
            hit_way0     <= 1'b0;
            hit_way1     <= 1'b0;
            load_way0    <= 1'b0;
            load_way1    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu.cpu_req) begin
                        addr_q       <= cpu.cpu_addr;
                        rw_q         <= cpu.cpu_rw;
                        index_dec    <= decode_index(cpu.cpu_addr[INDEX_LSB +: INDEX_W]);
                        cpu.cpu_busy <= 1'b1;
                        state        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (tag_hit0 || tag_hit1) begin
                        // a double hit is illegal; way0 takes priority
                        sel_q        <= !tag_hit0;
                        cycle_en     <= 1'b1;
                        hit_way0     <= tag_hit0;
                        hit_way1     <= !tag_hit0;
                        cpu.cpu_done <= 1'b1;
                        cpu.cpu_hit  <= !miss_q;
                        state        <= ST_DATA;
                    end else begin
                        miss_q   <= 1'b1;
                        victim_q <= victim_nxt;
                        mem_req  <= 1'b1;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        state <= ST_MEM_REQ;
                    end
                end
                ST_DATA: begin
                    miss_q       <= 1'b0;
                    cpu.cpu_busy <= 1'b0;
                    state        <= ST_IDLE;
                end
                ST_MEM_REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        load_way0 <= !victim_q;
                        load_way1 <= victim_q;
                        state     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    state <= ST_LOOKUP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phased_cache_ctrl.sv
// Scoreboard bench for phased_cache_ctrl: a small tag-array/memory
// environment answers the DUT, a reference cache model predicts each access.
module tb_phased_cache_ctrl;
    import phased_cache_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 4;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic              hit;
        logic              way;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic tag_hit0, tag_hit1, tag_valid0, tag_valid1;
    logic [INDEX_W-1:0]  index;
    logic [NUM_SETS-1:0] index_dec;
    logic [OFFSET_W-1:0] offset;
    logic cycle_en, rw, hit_way0, hit_way1, load_way0, load_way1, mem_req, mem_ack;
    logic [ADDR_W-5:0] mem_addr;
    logic [CNT_W-1:0]  miss_count;

    logic             env_clr;
    logic             dbl;
    logic [TAG_W-1:0] cur_tag;
    logic [TAG_W-1:0] env_tag   [NUM_SETS][NUM_WAYS];
    logic             env_valid [NUM_SETS][NUM_WAYS];

    logic [TAG_W-1:0] ref_tag   [NUM_SETS][NUM_WAYS];
    logic             ref_valid [NUM_SETS][NUM_WAYS];
    logic             ref_lru   [NUM_SETS];
    int               ref_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    phased_cache_ctrl_if #(.ADDR_W(ADDR_W)) cpu_bus ();

    phased_cache_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_bus.slave),
        .tag_hit0   (tag_hit0),
        .tag_hit1   (tag_hit1),
        .tag_valid0 (tag_valid0),
        .tag_valid1 (tag_valid1),
        .index      (index),
        .index_dec  (index_dec),
        .offset     (offset),
        .cycle_en   (cycle_en),
        .rw         (rw),
        .hit_way0   (hit_way0),
        .hit_way1   (hit_way1),
        .load_way0  (load_way0),
        .load_way1  (load_way1),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .miss_count (miss_count)
    );

    // Tag arrays as seen by the controller, indexed by its latched index
    always_comb begin
        tag_valid0 = env_valid[index][0];
        tag_valid1 = env_valid[index][1];
        tag_hit0   = dbl | (env_valid[index][0] && env_tag[index][0] == cur_tag);
        tag_hit1   = dbl | (env_valid[index][1] && env_tag[index][1] == cur_tag);
    end

    // Tag write on refill strobe
    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < NUM_SETS; i++)
                for (int j = 0; j < NUM_WAYS; j++)
                    env_valid[i][j] <= 1'b0;
        end else begin
            if (load_way0) begin
                env_valid[index][0] <= 1'b1;
                env_tag[index][0]   <= cur_tag;
            end
            if (load_way1) begin
                env_valid[index][1] <= 1'b1;
                env_tag[index][1]   <= cur_tag;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic w, input int ack_dly,
                         input bit dbl_hit, input bit poke);
        exp_t e;
        exp_t got;
        int   idx;
        int   cyc;
        int   req_cyc;
        int   n_fetch;
        int   n_load;
        bit   done;
        logic [TAG_W-1:0] t;

        idx = int'(a[INDEX_LSB +: INDEX_W]);
        t   = a[ADDR_W-1:TAG_LSB];
        cyc = 0;
        while (cpu_bus.cpu_busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_before_req", cpu_bus.cpu_busy, 0);

        e.addr = a;
        e.rw   = w;
        if (dbl_hit) begin
            e.hit = 1'b1; e.way = 1'b0;
        end else if (ref_valid[idx][0] && ref_tag[idx][0] == t) begin
            e.hit = 1'b1; e.way = 1'b0;
        end else if (ref_valid[idx][1] && ref_tag[idx][1] == t) begin
            e.hit = 1'b1; e.way = 1'b1;
        end else begin
            e.hit = 1'b0;
            e.way = !ref_valid[idx][0] ? 1'b0 : !ref_valid[idx][1] ? 1'b1 : ref_lru[idx];
            ref_tag[idx][e.way]   = t;
            ref_valid[idx][e.way] = 1'b1;
            if (ref_cnt < CNT_MAX) ref_cnt++;
        end
        ref_lru[idx] = ~e.way;
        sb.push_back(e);

        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_rw   = w;
        cpu_bus.cpu_addr = a;
        cur_tag          = t;
        dbl              = dbl_hit;
        @(negedge clk);
        cpu_bus.cpu_req = 1'b0;
        chk("busy_in_lookup", cpu_bus.cpu_busy, 1);

        cyc = 1; req_cyc = 0; n_fetch = 0; n_load = 0; done = 0;
        while (!done && cyc < 200) begin
            mem_ack         = 1'b0;
            cpu_bus.cpu_req = 1'b0;
            if (mem_req) begin
                if (req_cyc == 0) n_fetch++;
                chk("mem_addr", 32'(mem_addr), 32'(a[ADDR_W-1:INDEX_LSB]));
                if (poke && req_cyc == 1) begin
                    cpu_bus.cpu_req  = 1'b1;
                    cpu_bus.cpu_rw   = ~w;
                    cpu_bus.cpu_addr = ~a;
                end
                if (req_cyc == ack_dly) mem_ack = 1'b1;
                req_cyc++;
            end
            if (load_way0 || load_way1) begin
                n_load++;
                chk("load_way", {load_way1, load_way0}, e.way ? 2'b10 : 2'b01);
                chk("hit_during_load", {hit_way1, hit_way0}, 0);
                chk("mem_req_after_ack", mem_req, 0);
            end
            if (cpu_bus.cpu_done) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk("cpu_hit", cpu_bus.cpu_hit, got.hit);
                    chk("cycle_en", cycle_en, 1);
                    chk("hit_way", {hit_way1, hit_way0}, got.way ? 2'b10 : 2'b01);
                    chk("rw", rw, got.rw);
                    chk("offset", offset, got.addr[OFFSET_LSB +: OFFSET_W]);
                    chk("index", index, got.addr[INDEX_LSB +: INDEX_W]);
                    chk("index_dec", index_dec, 4'b0001 << got.addr[INDEX_LSB +: INDEX_W]);
                    chk("miss_count", miss_count, ref_cnt);
                    chk("fetches", n_fetch, got.hit ? 0 : 1);
                    chk("loads", n_load, got.hit ? 0 : 1);
                    chk("latency", cyc, got.hit ? 2 : 5 + ack_dly);
                end
                done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        mem_ack = 1'b0;
        dbl     = 1'b0;
        chk("done_pulse_width", cpu_bus.cpu_done, 0);
        chk("idle_after_done", cpu_bus.cpu_busy, 0);
    endtask

    initial begin
        int cyc;
        reset            = 1'b0;
        env_clr          = 1'b1;
        dbl              = 1'b0;
        mem_ack          = 1'b0;
        cur_tag          = '0;
        cpu_bus.cpu_req  = 1'b0;
        cpu_bus.cpu_rw   = 1'b0;
        cpu_bus.cpu_addr = '0;
        ref_cnt          = 0;
        for (int i = 0; i < NUM_SETS; i++) begin
            ref_lru[i] = 1'b0;
            for (int j = 0; j < NUM_WAYS; j++) begin
                ref_valid[i][j] = 1'b0;
                ref_tag[i][j]   = '0;
            end
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", cpu_bus.cpu_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_index_dec", index_dec, 0);
        chk("rst_miss_count", miss_count, 0);
        reset   = 1'b1;
        env_clr = 1'b0;
        @(negedge clk);

        // Abandon a line fetch with reset
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_addr = 16'h1230;
        cur_tag          = 16'h1230 >> TAG_LSB;
        @(negedge clk);
        cpu_bus.cpu_req = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_mem_req", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_busy", cpu_bus.cpu_busy, 0);
        chk("reset_strobes", {cycle_en, hit_way1, hit_way0, load_way1, load_way0, cpu_bus.cpu_done}, 0);
        chk("reset_miss_count", miss_count, 0);
        chk("reset_index_dec", index_dec, 0);
        chk("reset_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed sequence
        issue(16'h1025, 1'b0, 1, 0, 0);   // set2 miss -> way0
        issue(16'h0025, 1'b0, 0, 0, 0);   // set2 miss -> way1
        issue(16'h0025, 1'b0, 0, 0, 0);   // hit way1, lru[2]=0
        issue(16'h2010, 1'b0, 1, 0, 0);   // set1 miss -> way0
        issue(16'h3010, 1'b0, 1, 0, 0);   // set1 miss -> way1
        issue(16'h2010, 1'b0, 0, 0, 0);   // hit way0, lru[1]=1
        issue(16'h0010, 1'b0, 5, 0, 0);   // both valid, victim way1
        issue(16'h003F, 1'b1, 2, 0, 0);   // write miss, set3 fresh -> way0
        issue(16'h0025, 1'b0, 0, 1, 0);   // double hit, way0 wins
        issue(16'h4815, 1'b0, 4, 0, 1);   // cpu_req pulsed during MEM_REQ

        // Mixed traffic
        for (int k = 0; k < 24; k++) begin
            logic [ADDR_W-1:0] a;
            a = {10'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            issue(a, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0, 0);
        end

        // Round-robin over three tags in one set: every access misses
        for (int k = 0; k < 18; k++) begin
            logic [ADDR_W-1:0] a;
            a = {10'(7 + (k % 3)), 2'b00, 4'(k)};
            issue(a, 1'b0, 0, 0, 0);
        end
        chk("miss_count_saturated", miss_count, CNT_MAX);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
